// File: rtl/tickgen_pkg.sv
// tickgen_pkg
// Shared definitions for the multi-channel tick generator.
//   - Channel mode encodings (2 bits per channel on the mode bus).
//   - pre_width(): counter width needed to count 0..pre-1.
// Optional feature macro used by the files importing this package: TICKGEN_SYNC_EN.
package tickgen_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_TOGGLE  = 2'b01;
    localparam logic [1:0] MODE_PULSE   = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Width of a counter that must hold values 0..pre-1 (never narrower than 1 bit).
    function automatic int pre_width(input int pre);
        return (pre <= 2) ? 1 : $clog2(pre);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides CLK down to a one-cycle base tick at TICK_HZ (PRE = CLK_HZ/TICK_HZ clocks).
// Ports:
//   CLK    in   system clock
//   RST_N  in   asynchronous active-low reset
//   en     in   run enable; when low the count freezes and tick is forced low
//   sync   in   (only with TICKGEN_SYNC_EN) clears the count and any pending tick
//   tick   out  one-cycle pulse, high in the cycle after the count reaches PRE-1
// Optional feature macro: TICKGEN_SYNC_EN.
module tick_prescaler
    import tickgen_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
`ifdef TICKGEN_SYNC_EN
    input  logic sync,
`endif
    output logic tick
);

    localparam int PRE = CLK_HZ / TICK_HZ;
    localparam int PW  = pre_width(PRE);
    localparam logic [PW-1:0] LAST = PW'(PRE - 1);

    if (PRE < 2) begin : g_bad_pre
        $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;

    // A tick raised just before en drops is held rather than lost, and
    // released once en returns, so freezing never drops or adds a tick.
    always_comb begin
        pcnt_d = pcnt_q;
        tick_d = tick_q;
`ifdef TICKGEN_SYNC_EN
        if (sync) begin
            pcnt_d = '0;
            tick_d = 1'b0;
        end else
`endif
        if (en) begin
            tick_d = (pcnt_q == LAST);
            pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

`ifdef TICKGEN_SYNC_EN
    assign tick = tick_q & en & ~sync;
`else
    assign tick = tick_q & en;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi
// Prescaler plus NCH independent channels, each dividing the base tick by a
// runtime-loadable divisor and driving an output in OFF/TOGGLE/PULSE/ONESHOT mode.
// Ports:
//   CLK        in   system clock
//   RST_N      in   asynchronous active-low reset
//   en         in   global run enable (counters freeze, loads still accepted)
//   div_load   in   [NCH]     per-channel divisor load strobe
//   div_val    in   [DIV_W]   shared divisor value sampled on div_load
//   mode       in   [2*NCH]   per-channel mode, bits [2c+1:2c]
//   sync_all   in   (only with TICKGEN_SYNC_EN) phase-aligns every channel
//   tick_base  out  one-cycle base tick
//   ch_tick    out  [NCH]     one-cycle per-channel period-end pulse
//   ch_out     out  [NCH]     per-channel mode-dependent output
// Optional feature macro: TICKGEN_SYNC_EN.
module tick_gen_multi
    import tickgen_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int NCH       = 4,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 500
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               en,
    input  logic [NCH-1:0]     div_load,
    input  logic [DIV_W-1:0]   div_val,
    input  logic [2*NCH-1:0]   mode,
`ifdef TICKGEN_SYNC_EN
    input  logic               sync_all,
`endif
    output logic               tick_base,
    output logic [NCH-1:0]     ch_tick,
    output logic [NCH-1:0]     ch_out
);

    if ((NCH < 1) || (NCH > 16)) begin : g_bad_nch
        $error("tick_gen_multi: NCH must be in 1..16");
    end

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_pre (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (en),
`ifdef TICKGEN_SYNC_EN
        .sync  (sync_all),
`endif
        .tick  (tick_base)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [1:0]       mode_q, mode_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic             done_q, done_d;
        logic [1:0]       mode_c;

        assign mode_c = mode[2*c +: 2];

        // Priority: sync, load, mode change, idle (OFF or zero divisor),
        // finished oneshot, then normal counting. mode_q remembers last
        // cycle's mode so a change can be seen and used to restart the channel.
        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            mode_d = mode_c;
            out_d  = out_q;
            tick_d = 1'b0;
            done_d = done_q;
`ifdef TICKGEN_SYNC_EN
            if (sync_all) begin
                cnt_d  = '0;
                out_d  = 1'b0;
                done_d = 1'b0;
            end else
`endif
            if (div_load[c]) begin
                div_d  = div_val;
                cnt_d  = '0;
                out_d  = 1'b0;
                done_d = 1'b0;
            end else if (mode_c != mode_q) begin
                cnt_d  = '0;
                out_d  = 1'b0;
                done_d = 1'b0;
            end else if ((mode_c == MODE_OFF) || (div_q == '0)) begin
                cnt_d  = '0;
                out_d  = 1'b0;
                done_d = 1'b0;
            end else if ((mode_c == MODE_ONESHOT) && done_q) begin
                out_d = 1'b1;
            end else begin
                if (tick_base) begin
                    if (cnt_q == div_q - 1'b1) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                case (mode_c)
                    MODE_TOGGLE: begin
                        if (tick_d) begin
                            out_d = ~out_q;
                        end
                    end
                    MODE_PULSE: begin
                        out_d = tick_d;
                    end
                    MODE_ONESHOT: begin
                        if (tick_d) begin
                            out_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    end
                    default: begin
                        out_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                cnt_q  <= '0;
                div_q  <= DIV_W'(DIV_RESET);
                mode_q <= MODE_OFF;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                mode_q <= mode_d;
                out_q  <= out_d;
                tick_q <= tick_d;
                done_q <= done_d;
            end
        end

        assign ch_tick[c] = tick_q;
        assign ch_out[c]  = out_q;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi
// Directed, table-driven bench for tick_gen_multi with CLK_HZ=100, TICK_HZ=10
// (PRE=10), NCH=2, DIV_RESET=3. Edge numbers count rising edges after reset release.
// Optional feature macro: TICKGEN_SYNC_EN (enables the sync_all sequence).
module tb_tick_gen_multi;

    logic        CLK;
    logic        RST_N;
    logic        en;
    logic [1:0]  div_load;
    logic [15:0] div_val;
    logic [3:0]  mode;
    logic        sync_all;
    logic        tick_base;
    logic [1:0]  ch_tick;
    logic [1:0]  ch_out;

    int n_cmp;
    int n_fail;
    int cyc;

    typedef struct {
        int          edge_no;
        logic        en_v;
        logic [3:0]  mode_v;
        logic [1:0]  load_v;
        logic [15:0] val_v;
        logic        exp_tb;
        logic [1:0]  exp_tick;
        logic [1:0]  exp_out;
    } vec_t;

    vec_t vecs[$];

    tick_gen_multi #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .NCH       (2),
        .DIV_W     (16),
        .DIV_RESET (3)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (en),
        .div_load  (div_load),
        .div_val   (div_val),
        .mode      (mode),
`ifdef TICKGEN_SYNC_EN
        .sync_all  (sync_all),
`endif
        .tick_base (tick_base),
        .ch_tick   (ch_tick),
        .ch_out    (ch_out)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(int e, logic en_i, logic [3:0] m, logic [1:0] ld,
                                logic [15:0] v, logic tb_e, logic [1:0] tk, logic [1:0] o);
        vec_t r;
        r.edge_no  = e;
        r.en_v     = en_i;
        r.mode_v   = m;
        r.load_v   = ld;
        r.val_v    = v;
        r.exp_tb   = tb_e;
        r.exp_tick = tk;
        r.exp_out  = o;
        return r;
    endfunction

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        en       = 1'b0;
        mode     = 4'b0000;
        div_load = 2'b00;
        div_val  = 16'd0;
        sync_all = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc   = 0;
    endtask

    task automatic checkOutput(string tag, logic e_tb, logic [1:0] e_tick, logic [1:0] e_out);
        n_cmp++;
        if (tick_base !== e_tb) begin
            n_fail++;
            $display("[TB] FAIL %s tick_base: got %b expected %b", tag, tick_base, e_tb);
        end
        n_cmp++;
        if (ch_tick !== e_tick) begin
            n_fail++;
            $display("[TB] FAIL %s ch_tick: got %b expected %b", tag, ch_tick, e_tick);
        end
        n_cmp++;
        if (ch_out !== e_out) begin
            n_fail++;
            $display("[TB] FAIL %s ch_out: got %b expected %b", tag, ch_out, e_out);
        end
    endtask

    // Hold previous inputs up to the edge before the vector, drive the vector's
    // inputs for its edge, then check. Load strobes last a single cycle.
    task automatic applyStimulus(string scen, vec_t v);
        while (cyc < v.edge_no - 1) step();
        en       = v.en_v;
        mode     = v.mode_v;
        div_load = v.load_v;
        div_val  = v.val_v;
        step();
        div_load = 2'b00;
        checkOutput($sformatf("%s@%0d", scen, cyc), v.exp_tb, v.exp_tick, v.exp_out);
    endtask

    task automatic run_table(string scen);
        foreach (vecs[i]) applyStimulus(scen, vecs[i]);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;

        // Reset state, with active-looking inputs held during reset.
        RST_N    = 1'b0;
        en       = 1'b1;
        mode     = 4'b1010;
        div_load = 2'b00;
        div_val  = 16'd0;
        sync_all = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset", 1'b0, 2'b00, 2'b00);

        // PULSE on both channels, divisor 3: base tick every 10 edges,
        // channel pulses at 31, 61, 91.
        $display("[TB] pulse mode");
        do_reset();
        en   = 1'b1;
        mode = 4'b1010;
        for (int k = 1; k <= 100; k++) begin
            step();
            checkOutput($sformatf("pulse@%0d", k), (k % 10 == 0),
                        {2{(k >= 31) && ((k - 1) % 30 == 0)}},
                        {2{(k >= 31) && ((k - 1) % 30 == 0)}});
        end

        // TOGGLE, ch0 loaded with 2, ch1 on 3; async reset mid-count.
        $display("[TB] toggle mode");
        do_reset();
        vecs.delete();
        vecs.push_back(mk(1,  1'b1, 4'b0101, 2'b01, 16'd2, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(20, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mk(21, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b01, 2'b01));
        vecs.push_back(mk(31, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b10, 2'b11));
        vecs.push_back(mk(41, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b01, 2'b10));
        vecs.push_back(mk(61, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b11, 2'b01));
        vecs.push_back(mk(81, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b01, 2'b00));
        vecs.push_back(mk(91, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b10, 2'b10));
        vecs.push_back(mk(95, 1'b1, 4'b0101, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        run_table("toggle");
        #3;
        RST_N = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 2'b00, 2'b00);

        // ONESHOT with divisor 1, re-arm by load, then mode change to TOGGLE.
        $display("[TB] oneshot mode");
        do_reset();
        vecs.delete();
        vecs.push_back(mk(1,   1'b1, 4'b0011, 2'b01, 16'd1, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(10,  1'b1, 4'b0011, 2'b00, 16'd0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mk(11,  1'b1, 4'b0011, 2'b00, 16'd0, 1'b0, 2'b01, 2'b01));
        vecs.push_back(mk(12,  1'b1, 4'b0011, 2'b00, 16'd0, 1'b0, 2'b00, 2'b01));
        vecs.push_back(mk(120, 1'b1, 4'b0011, 2'b00, 16'd0, 1'b1, 2'b00, 2'b01));
        vecs.push_back(mk(121, 1'b1, 4'b0011, 2'b00, 16'd0, 1'b0, 2'b00, 2'b01));
        vecs.push_back(mk(125, 1'b1, 4'b0011, 2'b01, 16'd1, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(130, 1'b1, 4'b0011, 2'b00, 16'd0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mk(131, 1'b1, 4'b0011, 2'b00, 16'd0, 1'b0, 2'b01, 2'b01));
        vecs.push_back(mk(140, 1'b1, 4'b0001, 2'b00, 16'd0, 1'b1, 2'b00, 2'b00));
        vecs.push_back(mk(141, 1'b1, 4'b0001, 2'b00, 16'd0, 1'b0, 2'b01, 2'b01));
        run_table("oneshot");

        // Load coincident with ch0 period end, then a mid-period load.
        $display("[TB] load vs period end");
        do_reset();
        vecs.delete();
        vecs.push_back(mk(1,   1'b1, 4'b1010, 2'b00, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(31,  1'b1, 4'b1010, 2'b01, 16'd3, 1'b0, 2'b10, 2'b10));
        vecs.push_back(mk(32,  1'b1, 4'b1010, 2'b00, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(61,  1'b1, 4'b1010, 2'b00, 16'd0, 1'b0, 2'b11, 2'b11));
        vecs.push_back(mk(75,  1'b1, 4'b1010, 2'b01, 16'd3, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(91,  1'b1, 4'b1010, 2'b00, 16'd0, 1'b0, 2'b10, 2'b10));
        vecs.push_back(mk(101, 1'b1, 4'b1010, 2'b00, 16'd0, 1'b0, 2'b01, 2'b01));
        run_table("load");

        // en low for 37 edges (46..82) mid-period, then a zero-divisor load.
        $display("[TB] enable freeze");
        do_reset();
        vecs.delete();
        vecs.push_back(mk(1,   1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(31,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b11, 2'b11));
        vecs.push_back(mk(32,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(45,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(46,  1'b0, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(60,  1'b0, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(82,  1'b0, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(83,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(87,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b1, 2'b00, 2'b10));
        vecs.push_back(mk(88,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b10));
        vecs.push_back(mk(97,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b1, 2'b00, 2'b10));
        vecs.push_back(mk(98,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b11, 2'b01));
        vecs.push_back(mk(99,  1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(100, 1'b1, 4'b0110, 2'b01, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(108, 1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b00, 2'b00));
        vecs.push_back(mk(128, 1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b10, 2'b10));
        vecs.push_back(mk(158, 1'b1, 4'b0110, 2'b00, 16'd0, 1'b0, 2'b10, 2'b00));
        run_table("freeze");

`ifdef TICKGEN_SYNC_EN
        // Divisors 3 and 5 running, sync pulse at edge 45 realigns both.
        $display("[TB] sync_all");
        do_reset();
        en       = 1'b1;
        mode     = 4'b1010;
        div_load = 2'b10;
        div_val  = 16'd5;
        step();
        div_load = 2'b00;
        while (cyc < 44) step();
        sync_all = 1'b1;
        step();
        sync_all = 1'b0;
        checkOutput("sync_clear", 1'b0, 2'b00, 2'b00);
        for (int k = 1; k <= 60; k++) begin
            step();
            checkOutput($sformatf("sync+%0d", k), (k % 10 == 0),
                        {((k > 1) && (k % 50 == 1)), ((k > 1) && (k % 30 == 1))},
                        {((k > 1) && (k % 50 == 1)), ((k > 1) && (k % 30 == 1))});
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
